// File: rtl/regbank_dump_reader.sv
// regbank_dump_reader: walks registers 0..N-1 through the bank's async read port and streams each word LSB byte first over valid/ready
// Ports:
//   i_clk            clock, rising edge
//   i_reset_n        async reset, active low
//   i_start          start a dump, honoured only while idle
//   o_busy           high from the cycle after start until the done cycle ends
//   o_read_register  register index driven to the bank read port
//   i_read_data      bank read data, combinational on o_read_register
//   o_tx_data        byte to transmit
//   o_tx_valid       o_tx_data is valid
//   i_tx_ready       consumer accepts the byte this cycle
//   o_done           one-cycle pulse after the last byte is accepted
// Option REGBANK_DUMP_HEADER_EN: frame the stream with a leading 8'hA5 and a trailing XOR checksum of the data bytes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module regbank_dump_reader #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE = `DATA_WIDTH
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_start,
  output logic                                   o_busy,
  output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_read_register,
  input  logic [REGISTERS_SIZE-1:0]              i_read_data,
  output logic [7:0]                             o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic                                   o_done
);
  localparam int IW = $clog2(REGISTERS_BANK_SIZE);
  localparam int BYTES = REGISTERS_SIZE / 8;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_REG = IW'(REGISTERS_BANK_SIZE - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
`ifdef REGBANK_DUMP_HEADER_EN
    HEAD,
    CSUM,
`endif
    DONE
  } state_t;
  state_t state;
  logic [REGISTERS_SIZE-1:0] shift;
  logic [REGISTERS_SIZE-1:0] shift_nxt;
  logic [CW-1:0] cnt;
  logic hs;
`ifdef REGBANK_DUMP_HEADER_EN
  logic [7:0] csum;
`endif
  assign hs = o_tx_valid && i_tx_ready;
  assign shift_nxt = shift >> 8;
  // o_read_register doubles as the register index: it is loaded on entry to
  // LOAD so the bank data is already valid when LOAD captures it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      o_busy <= 1'b0;
      o_read_register <= '0;
      o_tx_data <= '0;
      o_tx_valid <= 1'b0;
      o_done <= 1'b0;
      shift <= '0;
      cnt <= '0;
`ifdef REGBANK_DUMP_HEADER_EN
      csum <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (i_start) begin
          o_busy <= 1'b1;
          o_read_register <= '0;
`ifdef REGBANK_DUMP_HEADER_EN
          csum <= '0;
          o_tx_data <= 8'hA5;
          o_tx_valid <= 1'b1;
          state <= HEAD;
`else
          state <= LOAD;
`endif
        end
`ifdef REGBANK_DUMP_HEADER_EN
        HEAD: if (hs) begin
          o_tx_valid <= 1'b0;
          state <= LOAD;
        end
`endif
        LOAD: begin
          shift <= i_read_data;
          cnt <= '0;
          o_tx_data <= i_read_data[7:0];
          o_tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (hs) begin
`ifdef REGBANK_DUMP_HEADER_EN
          csum <= csum ^ o_tx_data;
`endif
          if (cnt != LAST_BYTE) begin
            shift <= shift_nxt;
            cnt <= cnt + CW'(1);
            o_tx_data <= shift_nxt[7:0];
          end else if (o_read_register != LAST_REG) begin
            o_read_register <= o_read_register + IW'(1);
            o_tx_valid <= 1'b0;
            state <= LOAD;
          end else begin
`ifdef REGBANK_DUMP_HEADER_EN
            // csum does not yet include the byte being accepted now
            o_tx_data <= csum ^ o_tx_data;
            state <= CSUM;
`else
            o_tx_valid <= 1'b0;
            o_done <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef REGBANK_DUMP_HEADER_EN
        CSUM: if (hs) begin
          o_tx_valid <= 1'b0;
          o_done <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
